// File: rtl/cv32e40p_pkg.sv
// Shared definitions for the instruction-bus arbiter slice.
// Provides:
//   ibus_port_e     - requester ID carried through the owner FIFO
//   ibus_phase_e    - address-phase state (open / held awaiting grant)
//   ibus_other_port - helper returning the opposite requester
package cv32e40p_pkg;

    typedef enum logic {
        IBUS_PORT_FETCH = 1'b0,
        IBUS_PORT_AUX   = 1'b1
    } ibus_port_e;

    typedef enum logic {
        IBUS_ADDR_OPEN = 1'b0,
        IBUS_ADDR_HELD = 1'b1
    } ibus_phase_e;

    function automatic ibus_port_e ibus_other_port(input ibus_port_e p);
        return (p == IBUS_PORT_FETCH) ? IBUS_PORT_AUX : IBUS_PORT_FETCH;
    endfunction

endpackage

// File: rtl/cv32e40p_fifo.sv
// Small synchronous FIFO with optional fall-through.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   flush_i        - drop all entries
//   full_o/empty_o - occupancy flags
//   cnt_o          - number of stored entries (0..DEPTH)
//   data_i, push_i - write side (ignored when full)
//   data_o, pop_i  - read side (ignored when empty)
module cv32e40p_fifo #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH:0]   cnt_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_DEPTH-1:0] rd_ptr;
    logic [ADDR_DEPTH-1:0] wr_ptr;
    logic [ADDR_DEPTH:0]   status_cnt;
    logic                  do_push;
    logic                  do_pop;
    logic                  bypass;

    function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] p);
        if (p == ADDR_DEPTH'(DEPTH - 1)) begin
            return '0;
        end
        return p + ADDR_DEPTH'(1);
    endfunction

    assign full_o  = (status_cnt == (ADDR_DEPTH + 1)'(DEPTH));
    assign empty_o = (status_cnt == '0);
    assign cnt_o   = status_cnt;

    // In fall-through mode an empty FIFO passes a same-cycle push straight
    // to a same-cycle pop without storing it.
    assign bypass  = FALL_THROUGH && empty_o && push_i && pop_i;
    assign do_push = push_i && !full_o && !bypass;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = (FALL_THROUGH && empty_o) ? data_i : mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            status_cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            status_cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   status_cnt <= status_cnt + (ADDR_DEPTH + 1)'(1);
                2'b01:   status_cnt <= status_cnt - (ADDR_DEPTH + 1)'(1);
                default: status_cnt <= status_cnt;
            endcase
        end
    end

endmodule

// File: rtl/cv32e40p_instr_bus_arbiter.sv
// Two-to-one OBI instruction-bus arbiter.
// Port 0 is the prefetch buffer, port 1 an auxiliary fetch unit. Requests are
// arbitrated round-robin; an ungranted address phase locks the owner until
// the grant arrives. Up to DEPTH granted transactions may be outstanding;
// their owner IDs are queued so in-order responses return to the issuer.
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   pX_req_i/pX_addr_i/pX_gnt_o     - per-port address phase
//   pX_rvalid_o/pX_rdata_o/pX_err_o - per-port response phase
//   instr_*                         - shared bus
//   busy_o                          - transactions outstanding or request up
module cv32e40p_instr_bus_arbiter
    import cv32e40p_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        p0_req_i,
    input  logic [31:0] p0_addr_i,
    output logic        p0_gnt_o,
    output logic        p0_rvalid_o,
    output logic [31:0] p0_rdata_o,
    output logic        p0_err_o,

    input  logic        p1_req_i,
    input  logic [31:0] p1_addr_i,
    output logic        p1_gnt_o,
    output logic        p1_rvalid_o,
    output logic [31:0] p1_rdata_o,
    output logic        p1_err_o,

    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,

    output logic        busy_o
);

    localparam int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ibus_phase_e         phase_q;
    ibus_phase_e         phase_d;
    ibus_port_e          lock_owner;
    ibus_port_e          last_grant;
    ibus_port_e          owner;
    ibus_port_e          head;
    logic                lock;
    logic                req_sel;
    logic                granted;
    logic                resp_valid;
    logic                fifo_full;
    logic                fifo_empty;
    logic [0:0]          head_bit;
    logic [0:0]          owner_bit;
    logic [ADDR_DEPTH:0] cnt;

    assign lock = (phase_q == IBUS_ADDR_HELD);

    always_comb begin
        owner = IBUS_PORT_FETCH;
        if (lock) begin
            owner = lock_owner;
        end else if (p0_req_i && p1_req_i) begin
            owner = ibus_other_port(last_grant);
        end else if (p1_req_i) begin
            owner = IBUS_PORT_AUX;
        end
    end

    // Full FIFO gates the request; response in the same cycle does not
    // reopen it, keeping rvalid off the request path.
    assign req_sel      = (owner == IBUS_PORT_AUX) ? p1_req_i : p0_req_i;
    assign instr_req_o  = !fifo_full && req_sel;
    assign instr_addr_o = (owner == IBUS_PORT_AUX) ? p1_addr_i : p0_addr_i;

    assign granted  = instr_req_o && instr_gnt_i;
    assign p0_gnt_o = granted && (owner == IBUS_PORT_FETCH);
    assign p1_gnt_o = granted && (owner == IBUS_PORT_AUX);

    // A response with nothing outstanding is dropped.
    assign resp_valid  = instr_rvalid_i && !fifo_empty;
    assign head        = ibus_port_e'(head_bit[0]);
    assign p0_rvalid_o = resp_valid && (head == IBUS_PORT_FETCH);
    assign p1_rvalid_o = resp_valid && (head == IBUS_PORT_AUX);

    assign p0_rdata_o = instr_rdata_i;
    assign p1_rdata_o = instr_rdata_i;
    assign p0_err_o   = instr_err_i;
    assign p1_err_o   = instr_err_i;

    assign busy_o = (cnt != '0) || instr_req_o;

    always_comb begin
        phase_d = phase_q;
        if (granted) begin
            phase_d = IBUS_ADDR_OPEN;
        end else if (instr_req_o) begin
            phase_d = IBUS_ADDR_HELD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= IBUS_ADDR_OPEN;
            lock_owner <= IBUS_PORT_FETCH;
            last_grant <= IBUS_PORT_AUX;
        end else begin
            phase_q <= phase_d;
            if (granted) begin
                last_grant <= owner;
            end else if (instr_req_o) begin
                lock_owner <= owner;
            end
        end
    end

    assign owner_bit = owner;

    cv32e40p_fifo #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (1),
        .DEPTH        (DEPTH)
    ) owner_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .cnt_o   (cnt),
        .data_i  (owner_bit),
        .push_i  (granted),
        .data_o  (head_bit),
        .pop_i   (resp_valid)
    );

`ifdef CV32E40P_ASSERT_ON
    a_no_rvalid_when_idle : assert property (@(posedge clk) disable iff (!rst_n)
        instr_rvalid_i |-> (cnt != '0));
    a_cnt_bounded : assert property (@(posedge clk) disable iff (!rst_n)
        cnt <= (ADDR_DEPTH + 1)'(DEPTH));
    a_owner_stable_locked : assert property (@(posedge clk) disable iff (!rst_n)
        lock |-> (owner == $past(owner)));
    a_single_grant : assert property (@(posedge clk) disable iff (!rst_n)
        !(p0_gnt_o && p1_gnt_o));
`endif

endmodule

// File: tb/tb_cv32e40p_instr_bus_arbiter.sv
module tb_cv32e40p_instr_bus_arbiter;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req_i, p1_req_i;
    logic [31:0] p0_addr_i, p1_addr_i;
    logic        p0_gnt_o, p1_gnt_o;
    logic        p0_rvalid_o, p1_rvalid_o;
    logic [31:0] p0_rdata_o, p1_rdata_o;
    logic        p0_err_o, p1_err_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        instr_err_i = 1'b0;
    logic        busy_o;

    logic [1:0]  preq = '0;
    logic [31:0] paddr [2];

    assign p0_req_i  = preq[0];
    assign p1_req_i  = preq[1];
    assign p0_addr_i = paddr[0];
    assign p1_addr_i = paddr[1];

    always #5 clk = ~clk;

    cv32e40p_instr_bus_arbiter #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .p0_req_i       (p0_req_i),
        .p0_addr_i      (p0_addr_i),
        .p0_gnt_o       (p0_gnt_o),
        .p0_rvalid_o    (p0_rvalid_o),
        .p0_rdata_o     (p0_rdata_o),
        .p0_err_o       (p0_err_o),
        .p1_req_i       (p1_req_i),
        .p1_addr_i      (p1_addr_i),
        .p1_gnt_o       (p1_gnt_o),
        .p1_rvalid_o    (p1_rvalid_o),
        .p1_rdata_o     (p1_rdata_o),
        .p1_err_o       (p1_err_o),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .busy_o         (busy_o)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] bus_q[$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[4] & a[7];
    endfunction

    // Reference: queue of outstanding transactions, last-granted port and
    // the port whose address phase was shown but not yet accepted.
    int         m_last;
    bit         m_pending;
    int         m_pend_port;
    int         m_out;
    logic [1:0] gp;

    task automatic model_reset();
        exp_q.delete();
        bus_q.delete();
        m_last      = 1;
        m_pending   = 1'b0;
        m_pend_port = 0;
        m_out       = 0;
        gp          = '0;
    endtask

    task automatic drive_cycle(input int req_pct, input int gnt_pct, input int rv_pct);
        int          owner;
        bit          exp_req;
        logic [31:0] a;
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (!(preq[p] && !gp[p])) begin
                paddr[p] = $urandom & 32'hFFFF_FFFC;
                preq[p]  = ($urandom_range(99) < req_pct);
            end
        end
        instr_gnt_i = ($urandom_range(99) < gnt_pct);
        if (bus_q.size() > 0 && $urandom_range(99) < rv_pct) begin
            a              = bus_q.pop_front();
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = mem_data(a);
            instr_err_i    = mem_err(a);
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = $urandom;
            instr_err_i    = $urandom_range(1);
        end
        #3;
        if (m_pending)             owner = m_pend_port;
        else if (preq[0] && preq[1]) owner = 1 - m_last;
        else if (preq[1])          owner = 1;
        else                       owner = 0;
        exp_req = (m_out < int'(DEPTH)) && preq[owner];

        check("instr_req", instr_req_o, exp_req);
        if (exp_req) check("instr_addr", instr_addr_o, paddr[owner]);
        check("p0_gnt", p0_gnt_o, exp_req && instr_gnt_i && owner == 0);
        check("p1_gnt", p1_gnt_o, exp_req && instr_gnt_i && owner == 1);
        check("busy", busy_o, (m_out != 0) || exp_req);

        if (instr_req_o && instr_gnt_i) bus_q.push_back(instr_addr_o);
        gp = {p1_gnt_o, p0_gnt_o};
        if (exp_req && instr_gnt_i) begin
            exp_q.push_back('{port: owner, data: mem_data(paddr[owner]), err: mem_err(paddr[owner])});
            m_last    = owner;
            m_pending = 1'b0;
            m_out++;
        end else if (exp_req) begin
            m_pending   = 1'b1;
            m_pend_port = owner;
        end
        if (instr_rvalid_i) m_out--;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        preq           = '0;
        paddr[0]       = '0;
        paddr[1]       = '0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = 32'hDEAD_BEEF;
        instr_err_i    = 1'b1;
        #1;
        check("rst_instr_req", instr_req_o, 1'b0);
        check("rst_instr_addr", instr_addr_o, 32'h0);
        check("rst_p0_gnt", p0_gnt_o, 1'b0);
        check("rst_p1_gnt", p1_gnt_o, 1'b0);
        check("rst_p0_rvalid", p0_rvalid_o, 1'b0);
        check("rst_p1_rvalid", p1_rvalid_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_p0_rdata_mirror", p0_rdata_o, 32'hDEAD_BEEF);
        check("rst_p1_err_mirror", p1_err_o, 1'b1);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Response monitor: every cycle out of reset, compare the routed response
    // against the head of the expected queue.
    always @(negedge clk) begin
        resp_t e;
        if (rst_n) begin
            check("p0_rdata_mirror", p0_rdata_o, instr_rdata_i);
            if (instr_rvalid_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL resp_unexpected: got bus rvalid, expected no outstanding transaction at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("p0_rvalid", p0_rvalid_o, e.port == 0);
                    check("p1_rvalid", p1_rvalid_o, e.port == 1);
                    check("rdata", (e.port == 0) ? p0_rdata_o : p1_rdata_o, e.data);
                    check("err", (e.port == 0) ? p0_err_o : p1_err_o, e.err);
                end
            end else begin
                check("no_rvalid", {p1_rvalid_o, p0_rvalid_o}, 2'b00);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        paddr[0] = '0;
        paddr[1] = '0;
        model_reset();
        apply_reset();

        // Continuous contention with an always-granting bus: strict alternation.
        repeat (60)  drive_cycle(100, 100, 100);
        repeat (400) drive_cycle(60, 70, 40);
        // Slow responses drive the outstanding count to DEPTH.
        repeat (400) drive_cycle(80, 50, 15);
        // Sparse grants keep address phases locked for several cycles.
        repeat (300) drive_cycle(50, 25, 60);
        repeat (300) drive_cycle(90, 80, 80);

        // Fill to DEPTH with no responses, then reset mid-flight.
        repeat (8) drive_cycle(100, 100, 100);
        repeat (4) drive_cycle(100, 100, 0);
        apply_reset();
        repeat (40)  drive_cycle(100, 100, 100);
        repeat (300) drive_cycle(70, 60, 50);

        // Drain with no new requests.
        repeat (30) drive_cycle(0, 100, 100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
